// File: rtl/pipe_credit_tx.sv
// Credit-based link transmitter: accepts valid/ready items and pushes them over a
// registered valid-only link, using a credit counter to avoid overrunning the remote FIFO.
module pipe_credit_tx #(
    parameter type T = logic [31:0],
    parameter int CREDITS = 2,
    localparam int CW = $clog2(CREDITS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  T              data_in,
    input  logic          valid_in,
    output logic          ready_in,
    output T              data_out,
    output logic          valid_out,
    input  logic          credit_return_i,
    output logic [CW-1:0] credit_count_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic          valid_q, valid_d;
    T              data_q, data_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fire;

    // Upstream handshake: an item transfers in any cycle where valid_in && ready_in;
    // ready_in depends only on held credits and flush_i, never on valid_in.
    always_comb begin
        ready_in   = (count_q != '0) && !flush_i;
        fire       = valid_in && ready_in;
        valid_d    = fire;
        data_d     = fire ? data_in : data_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            // Credits still in flight are dropped along with the remote FIFO contents.
            count_d = FULL;
        end else if (fire && !credit_return_i) begin
            count_d = count_q - CW'(1);
        end else if (!fire && credit_return_i) begin
            if (count_q < FULL) begin
                count_d = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            count_q    <= FULL;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_out      = valid_q;
    assign data_out       = data_q;
    assign credit_count_o = count_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_pipe_credit_tx.sv
// Bench for pipe_credit_tx: directed vector table, hand-written corner sequences,
// and randomized traffic against a credit-counting reference model.
module tb_pipe_credit_tx;

    localparam int CREDITS = 2;
    localparam int CW = $clog2(CREDITS + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic [31:0]   data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [31:0]   data_out;
    logic          valid_out;
    logic          credit_return_i = 1'b0;
    logic [CW-1:0] credit_count_o;
    logic          overflow_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    pipe_credit_tx #(.CREDITS(CREDITS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out),
        .credit_return_i(credit_return_i), .credit_count_o(credit_count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush, valid, ret;
        logic [31:0] data;
        logic        exp_ready;
        int          exp_cnt;
        logic        exp_vo;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic f, logic v, logic r, logic [31:0] d, logic rdy,
                                int cnt, logic vo, logic [31:0] dout, logic ovf);
        vec_t x;
        x.flush = f; x.valid = v; x.ret = r; x.data = d; x.exp_ready = rdy;
        x.exp_cnt = cnt; x.exp_vo = vo; x.exp_data = dout; x.exp_ovf = ovf;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input logic [31:0] d);
        flush_i = f; valid_in = v; credit_return_i = r; data_in = d;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_count", 32'(credit_count_o), CREDITS);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_data", data_out, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Randomized-run reference model: held credits, sticky overflow, output register.
    int          m_cnt;
    logic        m_ovf;
    logic        m_vo;
    logic [31:0] m_data;

    initial begin
        // Directed vectors: {flush, valid, ret, data} -> ready during cycle, state after edge.
        vecs.push_back(mk(0, 0, 0, 32'h0,  1, 2, 0, 32'h0,  0)); // idle after reset
        vecs.push_back(mk(0, 1, 0, 32'hA,  1, 1, 1, 32'hA,  0)); // exhaust credits
        vecs.push_back(mk(0, 1, 0, 32'hB,  1, 0, 1, 32'hB,  0));
        vecs.push_back(mk(0, 1, 0, 32'hC,  0, 0, 0, 32'hB,  0)); // 0xC held off
        vecs.push_back(mk(0, 1, 1, 32'hC,  0, 1, 0, 32'hB,  0)); // credit returns
        vecs.push_back(mk(0, 1, 0, 32'hC,  1, 0, 1, 32'hC,  0)); // 0xC fires
        vecs.push_back(mk(0, 0, 0, 32'h0,  0, 0, 0, 32'hC,  0));
        vecs.push_back(mk(1, 1, 1, 32'hD,  0, 2, 0, 32'hC,  0)); // flush with coincident return
        vecs.push_back(mk(0, 0, 0, 32'h0,  1, 2, 0, 32'hC,  0));
        vecs.push_back(mk(0, 1, 1, 32'hE,  1, 2, 1, 32'hE,  0)); // fire+return at full: no overflow
        vecs.push_back(mk(0, 1, 0, 32'hF,  1, 1, 1, 32'hF,  0));
        vecs.push_back(mk(0, 1, 1, 32'h10, 1, 1, 1, 32'h10, 0)); // fire+return at count 1
        vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h10, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,  1, 2, 0, 32'h10, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,  1, 2, 0, 32'h10, 1)); // overflow
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 2, 0, 32'h10, 1)); // sticky through flush
        vecs.push_back(mk(0, 0, 0, 32'h0,  1, 2, 0, 32'h10, 1));

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].ret, vecs[i].data);
            @(negedge clk_i);
            check($sformatf("v%0d_ready", i), 32'(ready_in), 32'(vecs[i].exp_ready));
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_count", i), 32'(credit_count_o), vecs[i].exp_cnt);
            check($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_vo));
            check($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
        end

        // Asynchronous reset while a beat is on the link.
        drive(0, 1, 0, 32'h55);
        @(posedge clk_i);
        #1;
        check("pre_arst_valid", 32'(valid_out), 1);
        rst_i = 1'b1;
        #1;
        check("arst_valid", 32'(valid_out), 0);
        check("arst_count", 32'(credit_count_o), CREDITS);
        check("arst_ovf", 32'(overflow_o), 0);
        check("arst_data", data_out, 0);
        do_reset();

        // Streaming with credit loopback one cycle behind valid_out.
        exp_q.delete();
        for (int c = 0; c < 16; c++) begin
            if (c < 10) begin
                drive(0, 1, valid_out, 32'(c + 1));
                exp_q.push_back(32'(c + 1));
                @(negedge clk_i);
                check($sformatf("stream_ready%0d", c), 32'(ready_in), 1);
            end else begin
                drive(0, 0, valid_out, 32'h0);
            end
            @(posedge clk_i);
            #1;
            if (c < 10) check($sformatf("stream_valid%0d", c), 32'(valid_out), 1);
            if (valid_out) begin
                if (exp_q.size() == 0) check("stream_extra_beat", 32'(valid_out), 0);
                else check($sformatf("stream_data%0d", c), data_out, exp_q.pop_front());
            end
            if (c < 10) check($sformatf("stream_cnt_min%0d", c), 32'(credit_count_o >= 1), 1);
        end
        check("stream_drained", exp_q.size(), 0);
        check("stream_final_count", 32'(credit_count_o), CREDITS);

        // Randomized traffic against the reference model.
        do_reset();
        m_cnt = CREDITS; m_ovf = 1'b0; m_vo = 1'b0; m_data = '0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic f, v, r, rdy, fr;
            logic [31:0] d;
            f = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            d = $urandom;
            drive(f, v, r, d);
            rdy = (m_cnt > 0) && !f;
            fr = v && rdy;
            @(negedge clk_i);
            check("rnd_ready", 32'(ready_in), 32'(rdy));
            if (f) m_cnt = CREDITS;
            else if (fr && r) m_cnt = m_cnt;
            else if (fr) m_cnt = m_cnt - 1;
            else if (r && m_cnt < CREDITS) m_cnt = m_cnt + 1;
            else if (r) m_ovf = 1'b1;
            m_vo = fr;
            if (fr) begin
                m_data = d;
                exp_q.push_back(d);
            end
            @(posedge clk_i);
            #1;
            check("rnd_count", 32'(credit_count_o), m_cnt);
            check("rnd_valid", 32'(valid_out), 32'(m_vo));
            check("rnd_data_hold", data_out, m_data);
            check("rnd_ovf", 32'(overflow_o), 32'(m_ovf));
            if (valid_out) begin
                if (exp_q.size() == 0) check("rnd_extra_beat", 32'(valid_out), 0);
                else check("rnd_sb_data", data_out, exp_q.pop_front());
            end
        end
        check("rnd_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_credit_tx.md
# pipe_credit_tx

Credit-based transmitter for the far end of a pipeline link. Accepts items from a local valid/ready producer and drives them across a registered, push-only link (valid, no ready) to a remote receiver FIFO of known depth. Back-pressure is carried by a credit counter, so the link tolerates register stages between the ends. It pairs with a receiver that returns one credit pulse per item it pops.

## Interface
- T, logic [31:0], payload type.
- CREDITS, 2, remote receiver FIFO depth and initial credit count; legal range ≥ 1.
- CW, $clog2(CREDITS+1), credit counter width; derived, not overridable.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous flush; restarts the link in step with the remote receiver's flush.
- data_in  in  T  upstream payload.
- valid_in  in  1  upstream item valid.
- ready_in  out  1  upstream accept.
- data_out  out  T  registered link payload.
- valid_out  out  1  registered link valid; a one-cycle pulse per item.
- credit_return_i  in  1  one credit returned per cycle asserted.
- credit_count_o  out  CW  credits currently held.
- overflow_o  out  1  sticky error: a credit was returned while the counter was already at CREDITS.

## Operation
- Handshake rules:
  - ready_in = (credit_count_o != 0) && !flush_i. It is combinational from registered state and flush_i.
  - An item fires when valid_in && ready_in.
  - The link has no ready. The remote side must always accept a valid_out beat.
- Output register:
  - On a fire, data_out <= data_in and valid_out <= 1.
  - When nothing fires, valid_out <= 0 and data_out holds its last value.
  - Back-to-back fires give back-to-back valid_out beats.
- Credit counter update, applied in priority order:
  - If flush_i: count <= CREDITS, and credit_return_i is ignored.
  - If fire && credit_return_i: count is unchanged.
  - If fire alone: count <= count − 1.
  - If credit_return_i alone and count < CREDITS: count <= count + 1.
  - If credit_return_i alone and count == CREDITS: count is unchanged and overflow_o <= 1.
- Underflow cannot occur, because a fire requires count ≥ 1.
- overflow_o clears only on rst_i. It is unaffected by flush_i.
- Flush:
  - In the cycle flush_i is high, ready_in = 0, so no fire happens.
  - The next cycle has valid_out = 0.
  - The counter reloads to CREDITS.
  - Remote credits still in flight at the flush are discarded, consistent with the receiver's FIFO reset.

## Timing
- Reset values (asynchronous, take effect immediately on rst_i):
  - valid_out = 0, data_out = '0, credit_count_o = CREDITS, overflow_o = 0.
  - ready_in = 1 once rst_i deasserts, provided flush_i is low.
- Latency: data_in at the fire edge appears on data_out and valid_out after the same edge, i.e. one cycle.
- Credit effect: a credit_return_i pulse at edge N makes ready_in high in cycle N+1 when the count was 0.
- Throughput: with CREDITS ≥ link round-trip latency, 1 item/cycle is sustained. Otherwise throughput is CREDITS per round trip.
- Simultaneous fire + return at count 1: count stays 1, and ready_in stays high the next cycle.
- Simultaneous fire + return at count CREDITS: count stays CREDITS, and no overflow is flagged.
- Reset mid-stream: valid_out drops asynchronously and in-flight state is lost. The remote side must be reset together with this block.

## Test plan
- Reset, CREDITS=2:
  - Stimulus: hold valid_in = 0.
  - Expected: credit_count_o = 2, ready_in = 1, valid_out = 0, overflow_o = 0.
- Exhaust credits:
  - Stimulus: drive 0xA, 0xB, 0xC on consecutive cycles with no returns.
  - Expected: valid_out pulses carry 0xA then 0xB; count goes 2→1→0; ready_in = 0 while 0xC is held; valid_out = 0 in the third cycle.
- Credit release:
  - Stimulus: from count 0, pulse credit_return_i once.
  - Expected: next cycle ready_in = 1 and 0xC fires; valid_out with data_out = 0xC one cycle later; count returns to 0.
- Streaming, CREDITS=2:
  - Stimulus: 10 consecutive items 1..10, with the return loopback delayed 1 cycle.
  - Expected: all 10 emitted in order with no gaps; count never below 1.
- Flush:
  - Stimulus: at count 0 with a return pulse coincident, assert flush_i for 1 cycle.
  - Expected: ready_in = 0 during flush; next cycle count = 2, valid_out = 0, overflow_o = 0.
- Overflow:
  - Stimulus: at count 2, pulse credit_return_i.
  - Expected: count stays 2; overflow_o = 1 and stays 1 through a subsequent flush; clears only on rst_i.
